// File: rtl/pulse_stretch.sv
// -----------------------------------------------------------------------------
// pulse_stretch
//   Re-expands single-cycle event pulses into fixed-width high levels. A low gap
//   of at least GAP cycles always separates consecutive levels. Events that
//   arrive while the block is busy are queued in a saturating pending counter;
//   each queued event later produces its own level, so no two events are merged.
//
// Parameters
//   WIDTH    cycles y is held high per event (>=1)
//   GAP      minimum low cycles between consecutive y levels (>=1)
//   MAXPEND  maximum queued events (>=1)
//
// Ports
//   clk       in   1   clock, posedge
//   reset     in   1   asynchronous active-high reset
//   x         in   1   event pulse; every cycle sampled high is one event
//   y         out  1   stretched level (registered)
//   busy      out  1   level or gap in progress, or events queued (registered)
//   pending   out  PW  queued events not yet emitted (registered)
//   overflow  out  1   one-cycle pulse: an event was dropped, queue full
//
// Optional feature
//   PULSE_STRETCH_RETRIGGER_EN: x during a high level restarts the width
//   count and extends that level instead of queueing a new one.
// -----------------------------------------------------------------------------
module pulse_stretch #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned GAP     = 1,
  parameter int unsigned MAXPEND = 3,
  localparam int unsigned PW     = $clog2(MAXPEND + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          x,
  output logic          y,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  // Down-counter must hold max(WIDTH,GAP)-1; keep at least one bit.
  localparam int unsigned CMAX = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [PW-1:0] pend_q,  pend_d;
  logic          ovf_q,   ovf_d;
  logic          y_q,     y_d;
  logic          busy_q,  busy_d;
  logic          inc, dec;

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, queue bookkeeping and next output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = 1'b0;
    inc     = 1'b0;
    dec     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (x) begin
          state_d = ST_HIGH;
          cnt_d   = CW'(WIDTH - 1);
        end
      end

      ST_HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = ST_GAP;
          cnt_d   = CW'(GAP - 1);
        end
`ifdef PULSE_STRETCH_RETRIGGER_EN
        // Retrigger overrides the end-of-level transition as well.
        if (x) begin
          state_d = ST_HIGH;
          cnt_d   = CW'(WIDTH - 1);
        end
`else
        inc = x;
`endif
      end

      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          inc   = x;
        end else if (pend_q != '0) begin
          // Queued events are served first; a new x joins the back of the queue.
          state_d = ST_HIGH;
          cnt_d   = CW'(WIDTH - 1);
          dec     = 1'b1;
          inc     = x;
        end else if (x) begin
          state_d = ST_HIGH;
          cnt_d   = CW'(WIDTH - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Simultaneous push and pop leave the count unchanged, even when full.
    if (inc && !dec) begin
      if (pend_q == PW'(MAXPEND)) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PW'(1);
      end
    end else if (dec && !inc) begin
      pend_d = pend_q - PW'(1);
    end

    y_d    = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE) || (pend_d != '0);
  end

  assign y        = y_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretch
//   Self-checking bench for pulse_stretch (WIDTH=4, GAP=1, MAXPEND=3).
//   A timeline reference model tracks the current level as a window of cycle
//   numbers [m_start, m_hi_end]; a new level may begin once the window plus the
//   gap has elapsed. Fixed vectors, directed corner sequences and random
//   traffic are all compared against it and against hand-derived values.
// -----------------------------------------------------------------------------
module tb_pulse_stretch;

  localparam int unsigned W    = 4;
  localparam int unsigned G    = 1;
  localparam int unsigned MAXP = 3;
  localparam int unsigned PW   = $clog2(MAXP + 1);

  logic          clk;
  logic          reset;
  logic          x;
  logic          y;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int n_chk;
  int n_err;

  // Reference model state
  int m_cyc;
  int m_t;
  int m_start;
  int m_hi_end;
  int m_pend;
  bit m_ovf;

  typedef struct {
    logic x;
    logic y;
    logic busy;
    int   pend;
    logic ovf;
  } vec_t;

  vec_t vecs[11];

  pulse_stretch #(.WIDTH(W), .GAP(G), .MAXPEND(MAXP)) dut (
    .clk      (clk),
    .reset    (reset),
    .x        (x),
    .y        (y),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic mdl_reset();
    m_start  = -1000;
    m_hi_end = -1000;
    m_pend   = 0;
    m_ovf    = 0;
  endtask

  // One sampling edge of the model; outputs then describe the cycle after it.
  task automatic mdl_step(input bit xv);
    int  t;
    int  free_at;
    bit  retrig;
    t       = m_cyc;
    free_at = m_hi_end + int'(G) + 1;
    m_ovf   = 0;
    retrig  = 0;
    if (t >= free_at && m_pend > 0) begin
      m_start  = t;
      m_hi_end = t + int'(W) - 1;
      if (!xv) m_pend--;
    end else if (t >= free_at && xv) begin
      m_start  = t;
      m_hi_end = t + int'(W) - 1;
    end else if (xv) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
      retrig = (t - 1 <= m_hi_end);
`endif
      if (retrig) m_hi_end = t + int'(W) - 1;
      else if (m_pend == int'(MAXP)) m_ovf = 1;
      else m_pend++;
    end
    m_t = t;
    m_cyc++;
  endtask

  task automatic mdl_check();
    logic ey;
    logic eb;
    ey = (m_t >= m_start) && (m_t <= m_hi_end);
    eb = (m_t < m_hi_end + int'(G) + 1) || (m_pend > 0);
    chk("mdl_y",        32'(y),        32'(ey));
    chk("mdl_busy",     32'(busy),     32'(eb));
    chk("mdl_pending",  32'(pending),  32'(m_pend));
    chk("mdl_overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Apply x for one edge, advance the model, sample 1 time unit after the edge.
  task automatic tick(input logic xv);
    x = xv;
    @(posedge clk);
    if (reset) mdl_reset();
    else mdl_step(xv);
    #1;
    mdl_check();
  endtask

  // Short asynchronous reset pulse placed between edges.
  task automatic do_reset();
    x = 1'b0;
    reset = 1'b1;
    #2;
    mdl_reset();
    chk("rst_y",       32'(y),        32'd0);
    chk("rst_pending", 32'(pending),  32'd0);
    reset = 1'b0;
  endtask

  initial begin
    int   rises;
    logic prev_y;
    n_chk = 0;
    n_err = 0;
    m_cyc = 0;
    m_t   = 0;
    mdl_reset();

    // Two-event sequence: second event queued, separate levels with one low cycle.
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 0, 1'b0};

    // Reset state
    reset = 1'b1;
    x     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_y",        32'(y),        32'd0);
    chk("reset_busy",     32'(busy),     32'd0);
    chk("reset_pending",  32'(pending),  32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    tick(1'b0);

    // Single event: level of exactly WIDTH, busy clears after the gap.
    for (int k = 0; k < 8; k++) begin
      tick(k == 0);
      chk("single_y",       32'(y),       32'(k <= 3));
      chk("single_busy",    32'(busy),    32'(k <= 4));
      chk("single_pending", 32'(pending), 32'd0);
    end

    // Table vectors
    do_reset();
    for (int i = 0; i < 11; i++) begin
      tick(vecs[i].x);
      chk("vec_y",        32'(y),        32'(vecs[i].y));
      chk("vec_busy",     32'(busy),     32'(vecs[i].busy));
      chk("vec_pending",  32'(pending),  32'(vecs[i].pend));
      chk("vec_overflow", 32'(overflow), 32'(vecs[i].ovf));
    end

    // Burst of five: queue saturates, one overflow pulse, exactly four levels.
    do_reset();
    rises  = 0;
    prev_y = 1'b0;
    for (int k = 0; k < 22; k++) begin
      tick(k <= 4);
      if (y && !prev_y) rises++;
      prev_y = y;
      if (k == 3)  chk("burst_pend_full", 32'(pending),  32'd3);
      if (k == 4)  chk("burst_ovf_on",    32'(overflow), 32'd1);
      if (k == 5)  chk("burst_ovf_off",   32'(overflow), 32'd0);
      if (k == 14) chk("burst_pend_1",    32'(pending),  32'd1);
      if (k == 15) chk("burst_pend_0",    32'(pending),  32'd0);
    end
    chk("burst_levels", 32'(rises), 32'd4);

    // Asynchronous reset mid-operation discards the queue.
    do_reset();
    tick(1'b1);
    tick(1'b1);
    chk("rstmid_pend_before", 32'(pending), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid_y",       32'(y),       32'd0);
    chk("rstmid_pending", 32'(pending), 32'd0);
    chk("rstmid_busy",    32'(busy),    32'd0);
    mdl_reset();
    tick(1'b0);
    tick(1'b0);
    reset = 1'b0;
    tick(1'b0);
    tick(1'b0);
    for (int k = 6; k <= 11; k++) begin
      tick(k == 6);
      chk("rstmid_new_y", 32'(y), 32'(k <= 9));
      chk("rstmid_new_pending", 32'(pending), 32'd0);
    end

    // Event exactly on the gap exit with an empty queue is consumed directly.
    do_reset();
    for (int k = 0; k < 11; k++) begin
      tick(k == 0 || k == 5);
      chk("gapexit_y",       32'(y),       32'((k <= 3) || (k >= 5 && k <= 8)));
      chk("gapexit_pending", 32'(pending), 32'd0);
    end

    // Event during a high level: extends it (retrigger) or queues a new level.
    do_reset();
    for (int k = 0; k < 11; k++) begin
      tick(k == 0 || k == 2);
`ifdef PULSE_STRETCH_RETRIGGER_EN
      chk("retrig_y",       32'(y),       32'(k <= 5));
      chk("retrig_pending", 32'(pending), 32'd0);
`else
      chk("retrig_y", 32'(y), 32'((k <= 3) || (k >= 5 && k <= 8)));
`endif
    end

    // Random traffic of varying density with occasional resets.
    do_reset();
    for (int blk = 0; blk < 8; blk++) begin
      int dens;
      dens = $urandom_range(1, 6);
      for (int k = 0; k < 60; k++) begin
        if ($urandom_range(0, 149) == 0) do_reset();
        tick($urandom_range(0, dens - 1) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
